scp_079_sequencer: RTL and testbench

// - Controller that sequences the scp_079 containment FSM. It sits between operator inputs and scp_079.
// - Generates scp_079's green/yellow/red inputs, always one-hot, from prioritised operator requests.
// - Generates scp_079's timer input, which restarts whenever the colour or scp_079's state changes.
// - Latches scp_079's a1/a2/a3 alarms behind an acknowledge handshake.
// - Locks the unit into red when scp_079 reports sustained cheating.

---
 rtl/scp_pkg.sv | 36 +++
 rtl/scp_alarm_latch.sv | 61 ++++++
 rtl/scp_079_sequencer.sv | 143 ++++++++++++++
 tb/tb_scp_079_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scp_pkg.sv
// Shared encodings for the scp_079 sequencer: FSM states, alarm codes, colour one-hots.
package scp_pkg;

   localparam int unsigned COL_W       = 3;
   localparam int unsigned ALM_CODE_W  = 2;
   localparam int unsigned SCP_STATE_W = 3;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWELL = 2'd1,
      ALARM = 2'd2,
      LOCK  = 2'd3
   } fsm_e;

   localparam logic [ALM_CODE_W-1:0] ALM_NONE = 2'd0;
   localparam logic [ALM_CODE_W-1:0] ALM_A1   = 2'd1;
   localparam logic [ALM_CODE_W-1:0] ALM_A2   = 2'd2;
   localparam logic [ALM_CODE_W-1:0] ALM_A3   = 2'd3;

   // Colour vectors are {green, yellow, red}; COL_NONE marks an empty request slot.
   localparam logic [COL_W-1:0] COL_G    = 3'b100;
   localparam logic [COL_W-1:0] COL_Y    = 3'b010;
   localparam logic [COL_W-1:0] COL_R    = 3'b001;
   localparam logic [COL_W-1:0] COL_NONE = 3'b000;

   // Highest-priority requested colour (red > yellow > green), or COL_NONE.
   function automatic logic [COL_W-1:0] req_to_col(input logic g, input logic y, input logic r);
      logic [COL_W-1:0] col;
      col = COL_NONE;
      if (r)      col = COL_R;
      else if (y) col = COL_Y;
      else if (g) col = COL_G;
      return col;
   endfunction

endpackage

// File: rtl/scp_alarm_latch.sv
// Edge-detects the a1/a2/a3 alarms and holds the highest one until acknowledged.
module scp_alarm_latch
   import scp_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  a1,
   input  logic                  a2,
   input  logic                  a3,
   input  logic                  alarm_ack,
   output logic                  alarm_pending,
   output logic [ALM_CODE_W-1:0] alarm_code,
   output logic                  a3_rise_c
);

   logic [2:0]            alm_prev_q, alm_prev_d;
   logic                  pending_q, pending_d;
   logic [ALM_CODE_W-1:0] code_q, code_d;
   logic [2:0]            rise;
   logic [ALM_CODE_W-1:0] rise_code;

   // Rise detection, priority encode and pending/code update; a new rise beats an ack.
   always_comb begin
      alm_prev_d = {a3, a2, a1};
      pending_d  = pending_q;
      code_d     = code_q;
      rise       = {a3, a2, a1} & ~alm_prev_q;
      rise_code  = ALM_NONE;
      if (rise[2])      rise_code = ALM_A3;
      else if (rise[1]) rise_code = ALM_A2;
      else if (rise[0]) rise_code = ALM_A1;

      if (rise_code != ALM_NONE) begin
         if (!pending_q || alarm_ack || (rise_code > code_q)) begin
            pending_d = 1'b1;
            code_d    = rise_code;
         end
      end else if (alarm_ack) begin
         pending_d = 1'b0;
         code_d    = ALM_NONE;
      end
   end

   // Alarm latch registers; previous samples reset to 0 so alarms high at release count as rises.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alm_prev_q <= 3'b000;
         pending_q  <= 1'b0;
         code_q     <= ALM_NONE;
      end else begin
         alm_prev_q <= alm_prev_d;
         pending_q  <= pending_d;
         code_q     <= code_d;
      end
   end

   assign a3_rise_c     = a3 & ~alm_prev_q[2];
   assign alarm_pending = pending_q;
   assign alarm_code    = code_q;

endmodule

// File: rtl/scp_079_sequencer.sv
// Sequences the scp_079 colour/timer inputs from operator requests, alarms and cheat detection.
module scp_079_sequencer
   import scp_pkg::*;
#(
   parameter int unsigned TIMER_W    = 6,
   parameter int unsigned MIN_DWELL  = 4,
   parameter int unsigned CHEAT_HOLD = 3
)
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   req_green,
   input  logic                   req_yellow,
   input  logic                   req_red,
   input  logic [SCP_STATE_W-1:0] scp_state,
   input  logic                   a1,
   input  logic                   a2,
   input  logic                   a3,
   input  logic                   cheat_in,
   input  logic                   alarm_ack,
   output logic                   green,
   output logic                   yellow,
   output logic                   red,
   output logic [TIMER_W-1:0]     timer,
   output logic                   alarm_pending,
   output logic [ALM_CODE_W-1:0]  alarm_code,
   output logic                   lockout
);

   localparam int unsigned DWELL_W = $clog2(MIN_DWELL + 1);
   localparam int unsigned CHEAT_W = $clog2(CHEAT_HOLD + 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(MIN_DWELL - 1);
   localparam logic [CHEAT_W-1:0] CHEAT_MAX  = CHEAT_W'(CHEAT_HOLD);

   fsm_e                   state_q, state_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [COL_W-1:0]       col_prev_q, col_prev_d;
   logic [COL_W-1:0]       slot_q, slot_d;
   logic [DWELL_W-1:0]     dwell_q, dwell_d;
   logic [CHEAT_W-1:0]     cheat_q, cheat_d;
   logic [TIMER_W-1:0]     timer_q, timer_d;
   logic [SCP_STATE_W-1:0] scp_prev_q, scp_prev_d;
   logic                   lockout_q, lockout_d;

   logic [COL_W-1:0]       req_col;
   logic [COL_W-1:0]       slot_nx;
   logic                   timer_clr;
   logic                   a3_rise_c;

   scp_alarm_latch u_alarm_latch (
      .clock         (clock),
      .reset_n       (reset_n),
      .a1            (a1),
      .a2            (a2),
      .a3            (a3),
      .alarm_ack     (alarm_ack),
      .alarm_pending (alarm_pending),
      .alarm_code    (alarm_code),
      .a3_rise_c     (a3_rise_c)
   );

   // Request slot, cheat counter and timer update.
   always_comb begin
      req_col = req_to_col(req_green, req_yellow, req_red);
      slot_nx = slot_q;
      if (req_col != COL_NONE) begin
         slot_nx = (req_col == col_q) ? COL_NONE : req_col;
      end

      cheat_d = '0;
      if (cheat_in) begin
         cheat_d = (cheat_q == CHEAT_MAX) ? cheat_q : cheat_q + CHEAT_W'(1);
      end

      col_prev_d = col_q;
      scp_prev_d = scp_state;
      timer_clr  = (col_q != col_prev_q) || (scp_state != scp_prev_q);
      if (timer_clr)                 timer_d = '0;
      else if (timer_q == TIMER_MAX) timer_d = timer_q;
      else                           timer_d = timer_q + TIMER_W'(1);
   end

   // Next-state and colour logic, priority LOCK > ALARM > DWELL/RUN; the last dwell cycle acts like RUN.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      slot_d    = slot_nx;
      dwell_d   = dwell_q;
      lockout_d = lockout_q;

      if ((state_q == LOCK) || (cheat_d == CHEAT_MAX)) begin
         state_d   = LOCK;
         col_d     = COL_R;
         slot_d    = COL_NONE;
         lockout_d = 1'b1;
      end else if (a3_rise_c) begin
         state_d = ALARM;
         col_d   = COL_R;
      end else if (state_q == ALARM) begin
         if (alarm_ack) state_d = RUN;
      end else if ((state_q == DWELL) && (dwell_q != DWELL_LAST)) begin
         dwell_d = dwell_q + DWELL_W'(1);
      end else if (slot_nx != COL_NONE) begin
         col_d   = slot_nx;
         slot_d  = COL_NONE;
         dwell_d = '0;
         state_d = DWELL;
      end else begin
         state_d = RUN;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RUN;
         col_q      <= COL_G;
         col_prev_q <= COL_G;
         slot_q     <= COL_NONE;
         dwell_q    <= '0;
         cheat_q    <= '0;
         timer_q    <= '0;
         scp_prev_q <= '0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         col_prev_q <= col_prev_d;
         slot_q     <= slot_d;
         dwell_q    <= dwell_d;
         cheat_q    <= cheat_d;
         timer_q    <= timer_d;
         scp_prev_q <= scp_prev_d;
         lockout_q  <= lockout_d;
      end
   end

   assign {green, yellow, red} = col_q;
   assign timer                = timer_q;
   assign lockout              = lockout_q;

endmodule

// File: tb/tb_scp_079_sequencer.sv
// Directed bench for scp_079_sequencer with hand-computed expectations.
module tb_scp_079_sequencer;

   logic       clock;
   logic       reset_n;
   logic       req_green, req_yellow, req_red;
   logic [2:0] scp_state;
   logic       a1, a2, a3;
   logic       cheat_in;
   logic       alarm_ack;
   logic       green, yellow, red;
   logic [5:0] timer;
   logic       alarm_pending;
   logic [1:0] alarm_code;
   logic       lockout;

   int errors = 0;
   int checks = 0;

   scp_079_sequencer #(.TIMER_W(6), .MIN_DWELL(4), .CHEAT_HOLD(3)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_green     (req_green),
      .req_yellow    (req_yellow),
      .req_red       (req_red),
      .scp_state     (scp_state),
      .a1            (a1),
      .a2            (a2),
      .a3            (a3),
      .cheat_in      (cheat_in),
      .alarm_ack     (alarm_ack),
      .green         (green),
      .yellow        (yellow),
      .red           (red),
      .timer         (timer),
      .alarm_pending (alarm_pending),
      .alarm_code    (alarm_code),
      .lockout       (lockout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Colour checked as {green,yellow,red}.
   task automatic chk_col(input string tag, input logic [2:0] exp);
      chk(tag, 32'({green, yellow, red}), 32'(exp));
   endtask

   task automatic chk_alarm(input string tag, input logic pend, input logic [1:0] code);
      chk({tag, "_pend"}, 32'(alarm_pending), 32'(pend));
      chk({tag, "_code"}, 32'(alarm_code), 32'(code));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_col({tag, "_col"}, 3'b100);
      chk({tag, "_timer"}, 32'(timer), 32'd0);
      chk_alarm(tag, 1'b0, 2'd0);
      chk({tag, "_lock"}, 32'(lockout), 32'd0);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      {req_green, req_yellow, req_red} = 3'b000;
      scp_state = 3'd0;
      {a1, a2, a3} = 3'b000;
      cheat_in  = 1'b0;
      alarm_ack = 1'b0;

      // Reset state
      tick();
      chk_reset_vals("reset");
      reset_n = 1'b1;

      // Idle timer counts up and saturates at 63
      for (int k = 1; k <= 66; k++) begin
         tick();
         chk("timer_count", 32'(timer), 32'((k > 63) ? 63 : k));
      end
      chk_col("idle_green", 3'b100);

      // Yellow pulse applied next cycle, red request waits out the dwell
      req_yellow = 1'b1;
      tick();
      req_yellow = 1'b0;
      chk_col("yel_t1", 3'b010);
      chk("timer_t1", 32'(timer), 32'd63);
      tick();
      chk("timer_t2", 32'(timer), 32'd0);
      req_red = 1'b1;
      tick();
      req_red = 1'b0;
      chk_col("dwell_t3", 3'b010);
      chk("timer_t3", 32'(timer), 32'd1);
      tick();
      chk_col("dwell_t4", 3'b010);
      tick();
      chk_col("red_t5", 3'b001);
      tick();
      chk("timer_t6", 32'(timer), 32'd0);
      tick(); tick(); tick();
      chk("timer_t9", 32'(timer), 32'd3);

      // scp_state change alone restarts the timer
      scp_state = 3'd2;
      tick();
      chk("timer_st0", 32'(timer), 32'd0);
      tick();
      chk("timer_st1", 32'(timer), 32'd1);
      tick();
      chk("timer_st2", 32'(timer), 32'd2);
      chk_col("st_red", 3'b001);

      // Back to green, let dwell expire
      req_green = 1'b1;
      tick();
      req_green = 1'b0;
      chk_col("green_again", 3'b100);
      tick(); tick(); tick(); tick();

      // a1 then a3: upgrade, ALARM forces red, requests held
      a1 = 1'b1;
      tick();
      chk_alarm("a1_rise", 1'b1, 2'd1);
      chk_col("a1_green", 3'b100);
      a3 = 1'b1;
      tick();
      chk_alarm("a3_rise", 1'b1, 2'd3);
      chk_col("alarm_red", 3'b001);
      req_yellow = 1'b1;
      tick();
      req_yellow = 1'b0;
      tick();
      chk_col("alarm_hold", 3'b001);
      alarm_ack = 1'b1;
      tick();
      alarm_ack = 1'b0;
      chk_alarm("ack_clr", 1'b0, 2'd0);
      chk_col("ack_red", 3'b001);
      tick();
      chk_col("slot_applied", 3'b010);

      // Ack racing a new rise, lower rise ignored, ack clears, ack when idle
      a1 = 1'b0;
      a3 = 1'b0;
      tick();
      chk_alarm("no_rise", 1'b0, 2'd0);
      a1 = 1'b1;
      tick();
      chk_alarm("a1_again", 1'b1, 2'd1);
      a2 = 1'b1;
      alarm_ack = 1'b1;
      tick();
      alarm_ack = 1'b0;
      chk_alarm("ack_vs_a2", 1'b1, 2'd2);
      a1 = 1'b0;
      tick();
      a1 = 1'b1;
      tick();
      chk_alarm("lower_ign", 1'b1, 2'd2);
      alarm_ack = 1'b1;
      tick();
      alarm_ack = 1'b0;
      chk_alarm("ack2", 1'b0, 2'd0);
      alarm_ack = 1'b1;
      tick();
      alarm_ack = 1'b0;
      chk_alarm("ack_idle", 1'b0, 2'd0);
      a1 = 1'b0;
      a2 = 1'b0;
      tick(); tick(); tick();

      // Cheat for 2 cycles: no lockout
      cheat_in = 1'b1;
      tick(); tick();
      cheat_in = 1'b0;
      tick();
      chk("cheat2_lock", 32'(lockout), 32'd0);
      chk_col("cheat2_col", 3'b010);

      // Cheat for 3 cycles: lockout
      cheat_in = 1'b1;
      tick(); tick();
      chk("cheat_pre", 32'(lockout), 32'd0);
      tick();
      cheat_in = 1'b0;
      chk("cheat3_lock", 32'(lockout), 32'd1);
      chk_col("cheat3_red", 3'b001);
      req_green = 1'b1;
      tick();
      req_green = 1'b0;
      tick(); tick(); tick(); tick();
      chk_col("lock_ignores", 3'b001);
      chk("lock_stays", 32'(lockout), 32'd1);

      // Alarm latch still works in LOCK
      a3 = 1'b1;
      tick();
      chk_alarm("lock_a3", 1'b1, 2'd3);
      chk("lock_a3_lock", 32'(lockout), 32'd1);
      alarm_ack = 1'b1;
      tick();
      alarm_ack = 1'b0;
      a3 = 1'b0;
      chk_alarm("lock_ack", 1'b0, 2'd0);

      // Reset pulse exits LOCK
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
      chk("unlock", 32'(lockout), 32'd0);
      req_yellow = 1'b1;
      a2 = 1'b1;
      tick();
      req_yellow = 1'b0;
      chk_col("post_lock_yel", 3'b010);
      chk_alarm("pre_rst", 1'b1, 2'd2);
      tick();

      // Async reset mid-DWELL with alarm pending
      reset_n = 1'b0;
      #2;
      chk_reset_vals("async_rst");
      reset_n = 1'b1;
      tick();
      chk_alarm("rise_at_release", 1'b1, 2'd2);
      chk_col("release_green", 3'b100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
